fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per FIFO word and per serial frame payload.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are 2 or more.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1, which permits new frames to start while high.
REQ-006 The block SHALL have port empty, input, 1, the empty flag of the upstream FIFO.
REQ-007 The block SHALL have port read_data, input, DATA_WIDTH, the head word presented by the upstream FIFO's synchronous RAM.
REQ-008 The block SHALL have port read, output, 1, a one-cycle pop strobe to the upstream FIFO.
REQ-009 The block SHALL have port tx, output, 1, the serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse in the final stop-bit cycle.

Function
REQ-012 The block SHALL implement states IDLE, FETCH, START, DATA and STOP.
REQ-013 In IDLE, when enable=1 and empty=0 are sampled, the block SHALL move to FETCH on the next edge; otherwise it SHALL remain in IDLE.
REQ-014 FETCH SHALL last exactly one cycle, with read=1 during that cycle only.
REQ-015 At the end of FETCH, the block SHALL load read_data into a DATA_WIDTH shift register and move to START.
REQ-016 read SHALL be 0 in every state except FETCH, and SHALL never assert while empty=0 is unsampled.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-018 DATA SHALL drive DATA_WIDTH bits LSB first, each for CLKS_PER_BIT cycles.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-020 tx SHALL be registered and SHALL be 1 in IDLE and FETCH.
REQ-021 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-022 The bit-index counter SHALL count 0..DATA_WIDTH-1, with width sized as clog2 of DATA_WIDTH and a minimum of 1.
REQ-023 The total frame length, from the IDLE detect edge to the end of STOP, SHALL be 1 + (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-024 In the last STOP cycle, frame_done SHALL be 1; the next state SHALL be FETCH if enable=1 and empty=0, otherwise IDLE, giving back-to-back frames with exactly one tx=1 FETCH cycle between stop and next start.
REQ-025 When enable falls mid-frame, the current frame SHALL complete unchanged, and no further FETCH SHALL occur until enable=1.
REQ-026 Changes on empty or read_data outside IDLE, FETCH and the last STOP cycle SHALL be ignored.
REQ-027 read_data SHALL be sampled only at the end of FETCH; the required RAM latency is met because empty=0 held at least one cycle before FETCH.

Reset
REQ-028 While reset=0, the block SHALL immediately set state=IDLE, tx=1, read=0, busy=0, frame_done=0, and all counters and the shift register to 0, independent of clk.
REQ-029 Reset asserted mid-frame SHALL abort the frame; a word already popped SHALL be discarded and not retransmitted.
REQ-030 After reset release, the earliest read SHALL occur in the second cycle after release, with IDLE sampled in the first.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-031 The bench SHALL apply reset and hold empty=1, enable=1 for 100 cycles, and check tx=1, read=0, busy=0, frame_done=0 throughout.
REQ-032 The bench SHALL drive empty=0 with read_data=8'hA5, then check one read pulse one cycle after detect, tx=0 for 4 cycles, data 1,0,1,0,0,1,0,1 at 4 cycles each, tx=1 stop for 4 cycles, frame_done once, and a 41-cycle frame.
REQ-033 The bench SHALL present 8'h00 then 8'hFF with empty=0 throughout, and check exactly two read pulses, a second FETCH immediately after the first STOP, and the second payload all ones.
REQ-034 The bench SHALL drop enable to 0 during data bit 2 of a frame with empty=0, and check the frame completes, then no read and busy=0 until enable returns to 1.
REQ-035 The bench SHALL assert reset during data bit 3 between clk edges, and check tx=1 and busy=0 before the next edge; after release with empty=0, a fresh FETCH SHALL occur and a full frame SHALL follow.
REQ-036 The bench SHALL drive empty 0 then 1 within IDLE between samples, and check no read when empty=1 is sampled.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops words from an upstream synchronous-RAM FIFO
// and sends them as start / LSB-first data / stop frames on an idle-high line.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_MAX = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [BW-1:0]         idx, idx_nxt;
  logic [DATA_WIDTH-1:0] sh, sh_nxt;
  logic                  tx_q, tx_nxt;
  logic                  bit_end, go;

  assign bit_end = (cnt == CNT_MAX);
  assign go      = enable && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
      tx_q  <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    sh_nxt     = sh;
    read       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (go) state_nxt = FETCH;
      FETCH: begin
        read      = 1'b1;
        sh_nxt    = read_data;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end else cnt_nxt = cnt + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          sh_nxt  = sh >> 1;
          if (idx == IDX_MAX) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else idx_nxt = idx + 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = go ? FETCH : IDLE;
        end else cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Line level follows the state being entered so tx stays a pure flop output.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: words are queued as presented to the DUT
// and popped when a frame is decoded from tx; outputs sampled on negedge.
module tb_fifo_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic          empty = 1'b1;
  logic [DW-1:0] read_data = '0;
  logic          read, tx, busy, frame_done;

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty),
    .read_data(read_data), .read(read), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_read", read, 0);
      chk("idle_busy", busy, 0);
      chk("idle_fd", frame_done, 0);
    end
  endtask

  // Called on the negedge inside the expected FETCH cycle. The next head word
  // is presented only after the FETCH-closing edge, as a real FIFO would.
  task automatic check_frame(input logic nxt_empty, input logic [DW-1:0] nxt_data,
                             input int drop_en_cyc);
    logic [DW-1:0] exp, got;
    logic          e;
    int            bi;
    got = '0;
    exp = '0;
    chk("fetch_read", read, 1);
    chk("fetch_tx", tx, 1);
    chk("fetch_busy", busy, 1);
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) exp = sb.pop_front();
    for (int c = 1; c <= (DW + 2) * CPB; c++) begin
      @(negedge clk);
      if (c == 1) begin
        empty     = nxt_empty;
        read_data = nxt_data;
        if (!nxt_empty) sb.push_back(nxt_data);
      end
      if (c == drop_en_cyc) enable = 1'b0;
      bi = (c - CPB - 1) / CPB;
      if (c <= CPB) e = 1'b0;
      else if (c <= CPB * (DW + 1)) e = exp[bi];
      else e = 1'b1;
      chk("frame_tx", tx, e);
      chk("frame_read", read, 0);
      chk("frame_busy", busy, 1);
      chk("frame_done", frame_done, (c == (DW + 2) * CPB));
      if (c > CPB && c <= CPB * (DW + 1) && ((c - CPB - 1) % CPB) == CPB / 2)
        got[bi] = tx;
    end
    chk("payload", got, exp);
  endtask

  initial begin
    // Reset state, then a long quiet period with an empty FIFO.
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_read", read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b1;
    idle_chk(100);

    // Single frame 0xA5; read must follow the detect edge directly.
    empty = 1'b0; read_data = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    check_frame(1'b1, 8'h00, -1);
    idle_chk(5);

    // Back-to-back 0x00 then 0xFF: second FETCH right after the first STOP.
    empty = 1'b0; read_data = 8'h00; sb.push_back(8'h00);
    @(negedge clk);
    check_frame(1'b0, 8'hFF, -1);
    @(negedge clk);
    check_frame(1'b1, 8'h00, -1);
    idle_chk(10);

    // Enable drops during data bit 2: frame completes, then no more fetches.
    empty = 1'b0; read_data = 8'h5A; sb.push_back(8'h5A);
    @(negedge clk);
    check_frame(1'b0, 8'hC3, CPB + 1 + 2 * CPB + 1);
    idle_chk(20);
    enable = 1'b1;
    @(negedge clk);
    check_frame(1'b1, 8'h00, -1);
    idle_chk(5);

    // empty glitches low then back high before the sampling edge.
    empty = 1'b0; read_data = 8'h11;
    #2 empty = 1'b1;
    idle_chk(6);

    // Reset mid data bit 3; the popped 0x3C is dropped, 0x96 follows.
    empty = 1'b0; read_data = 8'h3C;
    @(negedge clk);
    chk("abort_fetch_read", read, 1);
    for (int c = 1; c <= CPB + 1 + 3 * CPB + 1; c++) begin
      @(negedge clk);
      if (c == 1) empty = 1'b1;
    end
    chk("abort_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_read", read, 0);
    chk("abort_fd", frame_done, 0);
    empty = 1'b0; read_data = 8'h96; sb.push_back(8'h96);
    @(negedge clk);
    chk("abort_hold_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    check_frame(1'b1, 8'h00, -1);
    idle_chk(5);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
